mips_controller: RTL and testbench

- Control unit of the single-cycle MIPS datapath.
- Decodes the 6-bit opcode (op) and 6-bit function field (funct) into datapath control signals and a 3-bit ALU control code.
- Built as a main decoder plus an ALU decoder, with all outputs registered on one clock.
- Sits between instruction memory and the datapath: regfile write-port mux, ALU source mux, data memory and PC-select logic.

---
 rtl/mips_controller.sv | 149 ++++++++++++++
 tb/tb_mips_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mips_controller.sv
// Single-cycle MIPS control unit: a main decoder and an ALU decoder feeding one
// bank of output registers, so every control signal lags op/funct by one clock.
module mips_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] aluctrl,
    output logic       memtoreg,
    output logic       memwrite,
    output logic       alusrc,
    output logic       regdst,
    output logic       regwrite,
    output logic       branch,
    output logic       jump,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    logic [1:0] aluop;
    logic       illegal_op;
    logic       illegal_funct;

    logic [2:0] aluctrl_next, aluctrl_reg;
    logic       memtoreg_next, memtoreg_reg;
    logic       memwrite_next, memwrite_reg;
    logic       alusrc_next, alusrc_reg;
    logic       regdst_next, regdst_reg;
    logic       regwrite_next, regwrite_reg;
    logic       branch_next, branch_reg;
    logic       jump_next, jump_reg;
    logic       illegal_next, illegal_reg;

    // Main decoder: unknown opcodes leave every write enable low.
    always_comb begin
        aluop         = ALUOP_ADD;
        illegal_op    = 1'b0;
        memtoreg_next = 1'b0;
        memwrite_next = 1'b0;
        alusrc_next   = 1'b0;
        regdst_next   = 1'b0;
        regwrite_next = 1'b0;
        branch_next   = 1'b0;
        jump_next     = 1'b0;
        case (op)
            OP_RTYPE: begin
                regwrite_next = 1'b1;
                regdst_next   = 1'b1;
                aluop         = ALUOP_FUNCT;
            end
            OP_LW: begin
                regwrite_next = 1'b1;
                alusrc_next   = 1'b1;
                memtoreg_next = 1'b1;
            end
            OP_SW: begin
                alusrc_next   = 1'b1;
                memwrite_next = 1'b1;
            end
            OP_BEQ: begin
                branch_next = 1'b1;
                aluop       = ALUOP_SUB;
            end
            OP_ADDI: begin
                regwrite_next = 1'b1;
                alusrc_next   = 1'b1;
            end
            OP_J:    jump_next  = 1'b1;
            default: illegal_op = 1'b1;
        endcase
    end

    // ALU decoder: funct only matters when the main decoder asks for it.
    always_comb begin
        aluctrl_next  = 3'b010;
        illegal_funct = 1'b0;
        case (aluop)
            ALUOP_ADD: aluctrl_next = 3'b010;
            ALUOP_SUB: aluctrl_next = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluctrl_next = 3'b010;
                    FN_SUB:  aluctrl_next = 3'b110;
                    FN_AND:  aluctrl_next = 3'b000;
                    FN_OR:   aluctrl_next = 3'b001;
                    FN_SLT:  aluctrl_next = 3'b111;
                    default: begin
                        aluctrl_next  = 3'b000;
                        illegal_funct = 1'b1;
                    end
                endcase
            end
            default: aluctrl_next = 3'b010;
        endcase
    end

    assign illegal_next = illegal_op | illegal_funct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluctrl_reg  <= 3'b000;
            memtoreg_reg <= 1'b0;
            memwrite_reg <= 1'b0;
            alusrc_reg   <= 1'b0;
            regdst_reg   <= 1'b0;
            regwrite_reg <= 1'b0;
            branch_reg   <= 1'b0;
            jump_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            aluctrl_reg  <= aluctrl_next;
            memtoreg_reg <= memtoreg_next;
            memwrite_reg <= memwrite_next;
            alusrc_reg   <= alusrc_next;
            regdst_reg   <= regdst_next;
            regwrite_reg <= regwrite_next;
            branch_reg   <= branch_next;
            jump_reg     <= jump_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign aluctrl  = aluctrl_reg;
    assign memtoreg = memtoreg_reg;
    assign memwrite = memwrite_reg;
    assign alusrc   = alusrc_reg;
    assign regdst   = regdst_reg;
    assign regwrite = regwrite_reg;
    assign branch   = branch_reg;
    assign jump     = jump_reg;
    assign illegal  = illegal_reg;

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: expected control words are queued when
// op/funct are driven and popped one clock later when the registers update.
module tb_mips_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic [2:0] aluctrl;
    logic       memtoreg, memwrite, alusrc, regdst, regwrite, branch, jump, illegal;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic [10:0] last_exp;

    mips_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .funct    (funct),
        .aluctrl  (aluctrl),
        .memtoreg (memtoreg),
        .memwrite (memwrite),
        .alusrc   (alusrc),
        .regdst   (regdst),
        .regwrite (regwrite),
        .branch   (branch),
        .jump     (jump),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {aluctrl[2:0], memtoreg, memwrite, alusrc, regdst, regwrite, branch, jump, illegal}
    function automatic logic [10:0] observed();
        return {aluctrl, memtoreg, memwrite, alusrc, regdst, regwrite, branch, jump, illegal};
    endfunction

    function automatic logic [10:0] model(input logic [5:0] o, input logic [5:0] f);
        logic [2:0] a;
        logic mtr, mw, as, rd, rw, br, jp, il;
        a = 3'b010; mtr = 0; mw = 0; as = 0; rd = 0; rw = 0; br = 0; jp = 0; il = 0;
        if (o == 6'd0) begin
            rw = 1; rd = 1;
            if      (f == 6'd32) a = 3'b010;
            else if (f == 6'd34) a = 3'b110;
            else if (f == 6'd36) a = 3'b000;
            else if (f == 6'd37) a = 3'b001;
            else if (f == 6'd42) a = 3'b111;
            else begin a = 3'b000; il = 1; end
        end
        else if (o == 6'd35) begin rw = 1; as = 1; mtr = 1; end
        else if (o == 6'd43) begin as = 1; mw = 1; end
        else if (o == 6'd4)  begin br = 1; a = 3'b110; end
        else if (o == 6'd8)  begin rw = 1; as = 1; end
        else if (o == 6'd2)  jp = 1;
        else il = 1;
        return {a, mtr, mw, as, rd, rw, br, jp, il};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (aluctrl,mtr,mw,as,rd,rw,br,j,ill)", tag, obs, exp);
        end
    endtask

    // Drive one decode, confirm the old word still holds before the edge,
    // then pop the queued word and compare it just after the edge.
    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f);
        logic [10:0] e;
        op = o;
        funct = f;
        exp_q.push_back(model(o, f));
        #2;
        check({tag, "_hold"}, last_exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, e);
        $display("step %-10s op=%b funct=%b out=%b exp=%b", tag, o, f, observed(), e);
        last_exp = e;
    endtask

    initial begin
        rst_n = 1'b0;
        op    = 6'b000000;
        funct = 6'b100000;
        last_exp = '0;

        // Reset held across clock edges keeps all outputs at zero.
        #3;
        check("reset_async", 11'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 11'b0);
        @(posedge clk);
        #1;
        check("first_edge", 11'b010_0_0_0_1_1_0_0_0);
        last_exp = 11'b010_0_0_0_1_1_0_0_0;

        step("r_add", 6'd0, 6'b100000);
        step("r_sub", 6'd0, 6'b100010);
        step("r_and", 6'd0, 6'b100100);
        step("r_or",  6'd0, 6'b100101);
        step("r_slt", 6'd0, 6'b101010);
        for (int i = 0; i <= 14; i++)
            step($sformatf("r_bad%0d", i), 6'd0, 6'(i));

        step("lw",   6'b100011, 6'b101010);
        step("sw",   6'b101011, 6'b000111);
        step("beq",  6'b000100, 6'b100000);
        step("j",    6'b000010, 6'b100101);
        step("addi", 6'b001000, 6'b100010);

        for (int i = 1; i <= 14; i++)
            step($sformatf("op%0d", i), 6'(i), 6'(i));
        step("op_3f", 6'b111111, 6'b100000);

        // Mid-run reset: outputs must drop without a clock edge.
        step("lw_pre", 6'b100011, 6'b000000);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 11'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_release", 11'b0);
        @(posedge clk);
        #1;
        check("midrst_resume", model(6'b100011, 6'b000000));
        last_exp = model(6'b100011, 6'b000000);
        step("sw_post", 6'b101011, 6'b000000);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_empty: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
